multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multicycle replacement for the single-cycle ARM control path. It sequences one shared ALU/memory datapath through fetch, decode, execute and writeback states, holding the NZCV flag register and evaluating condition codes. A memory-ready handshake stretches fetch and memory states so slow memory can be used. It sits between the instruction register fields and the datapath multiplexer and enable controls.

Parameters:
MEM_WAIT_EN, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST_N  in  1  asynchronous active-low reset.
Cond  in  4  instruction bits [31:28].
Op  in  2  instruction bits [27:26].
Funct  in  6  instruction bits [25:20].
Rd  in  4  instruction bits [15:12].
ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
MemReady  in  1  memory has completed the read or write this cycle.
PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write strobes.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
ALUSrcA  out  1  ALU A operand select: 0 = Rn, 1 = PC.
ALUSrcB  out  2  ALU B operand select: 00 = Rm, 01 = ExtImm, 10 = constant 4.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
ImmSrc, RegSrc  out  2 each  Op-decoded immediate and register-read selects.
Flags  out  4  registered NZCV.
InstrDone  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset (RST_N low, asynchronous): state = FETCH, Flags = 0000, CondEx latch = 0. All strobes and InstrDone are 0 while reset is asserted. A reset in any state abandons the instruction; no partial write occurs after reset is asserted.
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01). Both are combinational in every state.
- Default outputs in every state are 0 and ALUControl = ADD, unless the state list below says otherwise.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite = PCWrite = MemReady. Stay in FETCH until MemReady=1, then go to DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10 (PC+8). Latch CondEx = condcheck(Cond, Flags). Next state:
    - CondEx=0 or Op==11: go to FETCH and pulse InstrDone.
    - Op==01: go to MEMADR.
    - Op==10: go to BRANCH.
    - Op==00: go to EXECI if Funct[5]=1, else EXECR.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. ALUControl = ADD if Funct[3]=1 (U bit), else SUB. Go to MEMRD if Funct[0]=1 (L bit), else MEMWR.
  - MEMRD: AdrSrc=1. Hold until MemReady, then go to MEMWB.
  - MEMWB: ResultSrc=01. Assert PCWrite if Rd==1111, else RegWrite. Pulse InstrDone and go to FETCH.
  - MEMWR: AdrSrc=1, MemWrite=1 held steady until the MemReady cycle. Pulse InstrDone on that cycle and go to FETCH.
  - EXECR / EXECI: ALUSrcA=0; ALUSrcB = 00 for EXECR, 01 for EXECI. ALUControl is decoded from Funct[4:1]:
    - 0100 ADD → 00; 0010 SUB → 01; 0000 AND → 10; 1100 ORR → 11; 1010 CMP → 01.
    - Any other encoding decodes as ADD.
    - Go to ALUWB, except CMP, which pulses InstrDone and goes to FETCH.
  - ALUWB: ResultSrc=00. Assert PCWrite if Rd==1111, else RegWrite. Pulse InstrDone and go to FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1. Pulse InstrDone and go to FETCH.
- Flag update happens at the end of EXECR/EXECI, only when CondEx=1:
  - FlagW[1] = Funct[0] | CMP. It writes N and Z.
  - FlagW[0] = FlagW[1] & (ADD | SUB | CMP). It writes C and V.
  - Flags never change in any other state.
- condcheck follows the ARM table for codes 0000–1110 (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL). Code 1111 evaluates false.
- Latency with MemReady held at 1:
  - data-processing with writeback: 4 cycles; CMP: 3
  - LDR: 5; STR: 4
  - B: 3
  - failed condition or Op=11: 2
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemReady is ignored in every other state.

Decomposition:
- Shared package holds: the state encoding (4-bit enum, 10 states), ALUControl, ResultSrc and ALUSrcB code constants, and the Cond code constants.
- One sub-module, cond_check: a combinational Cond × Flags → CondEx function. The same sub-module is reusable by the single-cycle path.

Test Plan:
- Reset mid-MEMWR (MemReady=0, MemWrite=1), assert RST_N=0 → MemWrite drops to 0 immediately; after release, state=FETCH and Flags=0000.
- SUBS R1 (Funct=000101, Cond=1110), ALUFlags=0110, MemReady=1 → RegWrite in cycle 4, Flags=0110, InstrDone in cycle 4.
- CMP (Funct=010101) followed by BEQ with Z=1 (Cond=0000, Op=10) → CMP takes 3 cycles with no RegWrite; the branch asserts PCWrite in its cycle 3.
- BNE with Z=1 (Cond=0001) → DECODE goes straight to FETCH; no PCWrite beyond the FETCH increment; InstrDone at cycle 2.
- LDR (Op=01, Funct=011001) with MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD → RegWrite at cycle 10, ResultSrc=01.
- ADD with Rd=1111 → PCWrite=1 and RegWrite=0 in ALUWB. A data-processing op with Cond=1111 → no writes and no flag change.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multicycle ARM control path: state codes,
// datapath select codes, ALU command decode and condition codes.
package multicycle_sequencer_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unrecognised commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            CMD_CMP: alu_decode = ALU_SUB;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_cond_check.sv
// Combinational ARM condition evaluation of Cond against {N,Z,C,V};
// shared with the single-cycle control path. Code 1111 never executes.
module cond_check
    import multicycle_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle ARM control FSM: sequences the shared datapath through
// fetch/decode/execute/writeback, owns NZCV and stretches on MemReady.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on MemReady
// DECODE   | read registers, evaluate condition, dispatch on Op
// MEMADR   | compute load/store address Rn +/- imm
// MEMRD    | load data read, wait for MemReady
// MEMWB    | write loaded data to Rd (or PC)
// MEMWR    | store data write, wait for MemReady
// EXECR    | data-processing, register operand
// EXECI    | data-processing, immediate operand
// ALUWB    | write ALU result to Rd (or PC)
// BRANCH   | PC <= PC+8+imm
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic       InstrDone
);

    state_t     state;
    logic       cond_ex;
    logic       cond_ex_q;
    logic       mem_rdy;
    logic       is_cmp;
    logic       is_arith;
    logic [1:0] flag_w;
    logic       rd_is_pc;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    assign mem_rdy  = MEM_WAIT_EN ? MemReady : 1'b1;
    assign is_cmp   = (Funct[4:1] == CMD_CMP);
    assign is_arith = (Funct[4:1] == CMD_ADD) || (Funct[4:1] == CMD_SUB) || is_cmp;
    assign flag_w[1] = Funct[0] | is_cmp;
    assign flag_w[0] = flag_w[1] & is_arith;
    assign rd_is_pc = (Rd == 4'b1111);

    assign ImmSrc    = Op;
    assign RegSrc[0] = (Op == 2'b10);
    assign RegSrc[1] = (Op == 2'b01);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_FETCH;
            Flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    cond_ex_q <= cond_ex;
                    if (!cond_ex || Op == 2'b11) state <= S_FETCH;
                    else if (Op == 2'b01)        state <= S_MEMADR;
                    else if (Op == 2'b10)        state <= S_BRANCH;
                    else if (Funct[5])           state <= S_EXECI;
                    else                         state <= S_EXECR;
                end
                S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_rdy) state <= S_MEMWB;
                S_MEMWR:  if (mem_rdy) state <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    if (cond_ex_q) begin
                        if (flag_w[1]) Flags[3:2] <= ALUFlags[3:2];
                        if (flag_w[0]) Flags[1:0] <= ALUFlags[1:0];
                    end
                    state <= is_cmp ? S_FETCH : S_ALUWB;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RM;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        InstrDone  = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                InstrDone = ~cond_ex | (Op == 2'b11);
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                PCWrite   = rd_is_pc;
                RegWrite  = ~rd_is_pc;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = mem_rdy;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? SRCB_EXTIMM : SRCB_RM;
                ALUControl = alu_decode(Funct[4:1]);
                InstrDone  = is_cmp;
            end
            S_ALUWB: begin
                PCWrite   = rd_is_pc;
                RegWrite  = ~rd_is_pc;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the instruction: no strobe may leak while it is held.
        if (!RST_N) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: hand-timed instruction
// sequences with expected strobes, selects and flags per cycle.
module tb_multicycle_sequencer;

    logic       CLK;
    logic       RST_N;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite;
    logic       AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags;
    logic       InstrDone;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(.MEM_WAIT_EN(1'b1)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .Flags      (Flags),
        .InstrDone  (InstrDone)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller settles with #1.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic next();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST_N = 1'b0; Cond = 4'b1110; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
        ALUFlags = 4'b0000; MemReady = 1'b1;
        #2;
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_done", InstrDone, 0);
        chk("rst_flags", Flags, 4'b0000);

        // SUBS R1: flags 0110, writeback in cycle 4
        cyc(); RST_N = 1'b1; Op = 2'b00; Funct = 6'b000101; Rd = 4'd1; ALUFlags = 4'b0110; #1;
        chk("subs_c1_irwrite", IRWrite, 1);
        chk("subs_c1_pcwrite", PCWrite, 1);
        chk("subs_regsrc", RegSrc, 2'b00);
        next();
        chk("subs_c2_done", InstrDone, 0);
        next();
        chk("subs_c3_aluctl", ALUControl, 2'b01);
        chk("subs_c3_regwrite", RegWrite, 0);
        next();
        chk("subs_c4_regwrite", RegWrite, 1);
        chk("subs_c4_done", InstrDone, 1);
        chk("subs_flags", Flags, 4'b0110);

        // STR, reset asserted while MEMWR is stalled
        cyc(); Op = 2'b01; Funct = 6'b011000; Rd = 4'd3; ALUFlags = 4'b0000; #1;
        chk("str_c1_irwrite", IRWrite, 1);
        chk("str_immsrc", ImmSrc, 2'b01);
        chk("str_regsrc", RegSrc, 2'b10);
        next();
        chk("str_c2_done", InstrDone, 0);
        next();
        chk("str_c3_aluctl", ALUControl, 2'b00);
        chk("str_c3_srcb", ALUSrcB, 2'b01);
        cyc(); MemReady = 1'b0; #1;
        chk("str_c4_memwrite", MemWrite, 1);
        chk("str_c4_adrsrc", AdrSrc, 1);
        chk("str_c4_done", InstrDone, 0);
        next();
        chk("str_c5_memwrite", MemWrite, 1);
        RST_N = 1'b0; #1;
        chk("str_rst_memwrite", MemWrite, 0);
        chk("str_rst_flags", Flags, 4'b0000);

        // CMP setting Z, released straight into FETCH
        cyc(); RST_N = 1'b1; MemReady = 1'b1; Op = 2'b00; Funct = 6'b010101; Rd = 4'd0;
        ALUFlags = 4'b0100; #1;
        chk("post_rst_irwrite", IRWrite, 1);
        chk("post_rst_flags", Flags, 4'b0000);
        next();
        chk("cmp_c2_done", InstrDone, 0);
        next();
        chk("cmp_c3_aluctl", ALUControl, 2'b01);
        chk("cmp_c3_done", InstrDone, 1);
        chk("cmp_c3_regwrite", RegWrite, 0);

        // BEQ taken
        cyc(); Op = 2'b10; Cond = 4'b0000; ALUFlags = 4'b0000; #1;
        chk("beq_flags", Flags, 4'b0100);
        chk("beq_regsrc", RegSrc, 2'b01);
        next();
        chk("beq_c2_done", InstrDone, 0);
        next();
        chk("beq_c3_pcwrite", PCWrite, 1);
        chk("beq_c3_done", InstrDone, 1);
        chk("beq_c3_srcb", ALUSrcB, 2'b01);

        // BNE not taken
        cyc(); Cond = 4'b0001; #1;
        chk("bne_c1_pcwrite", PCWrite, 1);
        next();
        chk("bne_c2_done", InstrDone, 1);
        chk("bne_c2_pcwrite", PCWrite, 0);

        // LDR with 2 fetch stalls and 3 read stalls: writeback in cycle 10
        cyc(); Cond = 4'b1110; Op = 2'b01; Funct = 6'b011001; Rd = 4'd2; MemReady = 1'b0; #1;
        chk("ldr_c1_irwrite", IRWrite, 0);
        chk("ldr_c1_pcwrite", PCWrite, 0);
        next();
        chk("ldr_c2_irwrite", IRWrite, 0);
        cyc(); MemReady = 1'b1; #1;
        chk("ldr_c3_irwrite", IRWrite, 1);
        next();
        chk("ldr_c4_done", InstrDone, 0);
        next();
        chk("ldr_c5_aluctl", ALUControl, 2'b00);
        cyc(); MemReady = 1'b0; #1;
        chk("ldr_c6_adrsrc", AdrSrc, 1);
        next();
        next();
        chk("ldr_c8_adrsrc", AdrSrc, 1);
        chk("ldr_c8_done", InstrDone, 0);
        cyc(); MemReady = 1'b1; #1;
        chk("ldr_c9_regwrite", RegWrite, 0);
        next();
        chk("ldr_c10_regwrite", RegWrite, 1);
        chk("ldr_c10_ressrc", ResultSrc, 2'b01);
        chk("ldr_c10_done", InstrDone, 1);

        // ADD immediate to PC
        cyc(); Op = 2'b00; Funct = 6'b101000; Rd = 4'd15; #1;
        next();
        next();
        chk("addpc_c3_srcb", ALUSrcB, 2'b01);
        chk("addpc_c3_aluctl", ALUControl, 2'b00);
        next();
        chk("addpc_c4_pcwrite", PCWrite, 1);
        chk("addpc_c4_regwrite", RegWrite, 0);
        chk("addpc_c4_done", InstrDone, 1);

        // ORRS updates N,Z only
        cyc(); Funct = 6'b011001; Rd = 4'd4; ALUFlags = 4'b1011; #1;
        next();
        next();
        chk("orrs_c3_aluctl", ALUControl, 2'b11);
        next();
        chk("orrs_c4_regwrite", RegWrite, 1);
        chk("orrs_flags", Flags, 4'b1000);

        // Cond 1111: never executes
        cyc(); Cond = 4'b1111; Funct = 6'b000101; ALUFlags = 4'b1111; #1;
        next();
        chk("nv_c2_done", InstrDone, 1);
        chk("nv_c2_regwrite", RegWrite, 0);
        next();
        chk("nv_c3_irwrite", IRWrite, 1);
        chk("nv_c3_regwrite", RegWrite, 0);
        chk("nv_flags", Flags, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
